// File: rtl/pipeline_run_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_run_ctrl : host-driven load/run/step/clear controller for the
//                     five-stage MIPS core, with a registered response channel.
// Revision 1.0
// ============================================================================
module pipeline_run_ctrl #(
    parameter int IMEM_AW      = 8,
    parameter int CLEAR_CYCLES = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [2:0]         i_cmd_op,
    input  logic [31:0]        i_cmd_data,
    output logic               o_rsp_valid,
    input  logic               i_rsp_ready,
    output logic [31:0]        o_rsp_data,
    output logic               o_imem_we,
    output logic [IMEM_AW-1:0] o_imem_addr,
    output logic [31:0]        o_imem_wdata,
    output logic               o_cpu_en,
    output logic               o_cpu_clear,
    input  logic               i_halt,
    input  logic [31:0]        i_result,
    output logic               o_running
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_STEP     = 3'd2,
        ST_STEP_RSP = 3'd3,
        ST_CLEAR    = 3'd4
    } state_t;

    localparam logic [2:0]  OP_NOP     = 3'd0;
    localparam logic [2:0]  OP_LOAD    = 3'd1;
    localparam logic [2:0]  OP_RUN     = 3'd2;
    localparam logic [2:0]  OP_STEP    = 3'd3;
    localparam logic [2:0]  OP_STOP    = 3'd4;
    localparam logic [2:0]  OP_STATUS  = 3'd5;
    localparam logic [2:0]  OP_CLEAR   = 3'd6;
    localparam logic [31:0] RSP_ERR    = 32'hFFFF_FFFF;
    localparam logic [7:0]  CLEAR_LAST = 8'(CLEAR_CYCLES - 1);

    state_t               state_q, state_d;
    logic [IMEM_AW-1:0]   ptr_q, ptr_d;
    logic [IMEM_AW-1:0]   imem_addr_q, imem_addr_d;
    logic [31:0]          imem_wdata_q, imem_wdata_d;
    logic                 imem_we_q, imem_we_d;
    logic [31:0]          cyc_q, cyc_d;
    logic                 halted_q, halted_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_data_q, rsp_data_d;
    logic [7:0]           clr_cnt_q, clr_cnt_d;

    logic                 running;
    logic                 cpu_en;
    logic                 cmd_accept;
    logic [IMEM_AW-1:0]   ptr_inc;
    logic [31:0]          status_word;
    logic                 rsp_load;
    logic [31:0]          rsp_word;

    assign running     = (state_q == ST_RUN);
    assign cpu_en      = running || (state_q == ST_STEP);
    // A stalled response blocks new commands unless it drains this very edge.
    assign o_cmd_ready = ((state_q == ST_IDLE) || running) && !(rsp_valid_q && !i_rsp_ready);
    assign cmd_accept  = i_cmd_valid && o_cmd_ready;
    assign ptr_inc     = ptr_q + IMEM_AW'(1);
    assign status_word = {halted_q, running, 6'b0, 8'(ptr_q), cyc_q[15:0]};

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        halted_d     = halted_q;
        clr_cnt_d    = clr_cnt_q;
        cyc_d        = (cpu_en && (cyc_q != 32'hFFFF_FFFF)) ? cyc_q + 32'd1 : cyc_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        rsp_load     = 1'b0;
        rsp_word     = 32'd0;

        if (cpu_en && i_halt) begin
            halted_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_accept) begin
                    case (i_cmd_op)
                        OP_NOP: ;
                        OP_LOAD: begin
                            imem_we_d    = 1'b1;
                            imem_addr_d  = ptr_q;
                            imem_wdata_d = i_cmd_data;
                            ptr_d        = ptr_inc;
                            rsp_load     = 1'b1;
                            rsp_word     = 32'(ptr_inc);
                        end
                        OP_RUN: begin
                            rsp_load = 1'b1;
                            if (halted_q) begin
                                rsp_word = RSP_ERR;
                            end else begin
                                state_d = ST_RUN;
                            end
                        end
                        OP_STEP: begin
                            if (halted_q) begin
                                rsp_load = 1'b1;
                                rsp_word = RSP_ERR;
                            end else begin
                                state_d = ST_STEP;
                            end
                        end
                        OP_STOP: begin
                            rsp_load = 1'b1;
                            rsp_word = cyc_q;
                        end
                        OP_STATUS: begin
                            rsp_load = 1'b1;
                            rsp_word = status_word;
                        end
                        OP_CLEAR: begin
                            state_d   = ST_CLEAR;
                            clr_cnt_d = CLEAR_LAST;
                        end
                        default: begin
                            rsp_load = 1'b1;
                            rsp_word = RSP_ERR;
                        end
                    endcase
                end
            end
            ST_RUN: begin
                if (i_halt) begin
                    state_d = ST_IDLE;
                end
                if (cmd_accept) begin
                    case (i_cmd_op)
                        OP_NOP: ;
                        OP_STOP: begin
                            // Count includes the cycle ending at this edge.
                            state_d  = ST_IDLE;
                            rsp_load = 1'b1;
                            rsp_word = cyc_d;
                        end
                        OP_STATUS: begin
                            rsp_load = 1'b1;
                            rsp_word = status_word;
                        end
                        default: begin
                            rsp_load = 1'b1;
                            rsp_word = RSP_ERR;
                        end
                    endcase
                end
            end
            ST_STEP: begin
                state_d  = ST_STEP_RSP;
                rsp_load = 1'b1;
                rsp_word = i_result;
            end
            ST_STEP_RSP: begin
                state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                if (clr_cnt_q == 8'd0) begin
                    state_d  = ST_IDLE;
                    ptr_d    = '0;
                    cyc_d    = 32'd0;
                    halted_d = 1'b0;
                    rsp_load = 1'b1;
                    rsp_word = 32'd0;
                end else begin
                    clr_cnt_d = clr_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rsp_valid_d = rsp_load || (rsp_valid_q && !i_rsp_ready);
        rsp_data_d  = rsp_load ? rsp_word : rsp_data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            imem_we_q    <= 1'b0;
            cyc_q        <= 32'd0;
            halted_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 32'd0;
            clr_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            imem_we_q    <= imem_we_d;
            cyc_q        <= cyc_d;
            halted_q     <= halted_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            clr_cnt_q    <= clr_cnt_d;
        end
    end

    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_data   = rsp_data_q;
    assign o_imem_we    = imem_we_q;
    assign o_imem_addr  = imem_addr_q;
    assign o_imem_wdata = imem_wdata_q;
    assign o_cpu_en     = cpu_en;
    assign o_cpu_clear  = (state_q == ST_CLEAR);
    assign o_running    = running;

endmodule
`default_nettype wire
